omok_win_detector: RTL and testbench

//  Sits downstream of the board-state register and beside the LCD renderer. Watches board_state/turn_map
//  for newly placed stones. For each new stone, walks the 4 line directions around that cell one cell per

---
 rtl/omok_pkg.sv | 27 ++
 rtl/omok_new_stone_enc.sv | 19 +
 rtl/omok_win_detector.sv | 148 ++++++++++++++
 tb/tb_omok_win_detector.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/omok_pkg.sv
// Shared constants, encodings and the line-direction table for the omok win detector.
package omok_pkg;
  localparam int BOARD_N = 10;
  localparam int CELLS   = BOARD_N * BOARD_N;
  localparam int IDX_W   = 7;

  localparam logic BLACK = 1'b0;
  localparam logic WHITE = 1'b1;

  typedef enum logic [1:0] {DIR_E, DIR_S, DIR_SE, DIR_SW} dir_e;
  typedef enum logic [2:0] {IDLE, DIR_INIT, STEP_POS, STEP_NEG, EVAL, FIN} state_e;

  // Signed so that stepping off the top/left edge goes negative instead of wrapping.
  typedef logic signed [4:0] coord_t;

  function automatic coord_t dir_dr(input dir_e d);
    return (d == DIR_E) ? 5'sd0 : 5'sd1;
  endfunction

  function automatic coord_t dir_dc(input dir_e d);
    case (d)
      DIR_E, DIR_SE: return 5'sd1;
      DIR_S:         return 5'sd0;
      default:       return -5'sd1;
    endcase
  endfunction
endpackage

// File: rtl/omok_new_stone_enc.sv
// Lowest-set-bit priority encoder: picks the lowest-index newly placed stone.
module omok_new_stone_enc import omok_pkg::*; #(
  parameter int N = CELLS
) (
  input  logic [N-1:0]     req,
  output logic             any,
  output logic [IDX_W-1:0] index
);
  always_comb begin
    any   = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any   = 1'b1;
        index = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/omok_win_detector.sv
// Scans the four lines through each newly placed stone, one cell per cycle,
// and latches a sticky win flag with the winning colour and completing cell.
module omok_win_detector #(
  parameter int BOARD_N = 10,
  parameter int WIN_LEN = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BOARD_N*BOARD_N-1:0] board_state,
  input  logic [BOARD_N*BOARD_N-1:0] turn_map,
  output logic                       busy,
  output logic                       done,
  output logic                       win,
  output logic                       winner,
  output logic [6:0]                 win_pos
);
  import omok_pkg::*;

  localparam int NC = BOARD_N * BOARD_N;
  localparam int CW = $clog2(2 * WIN_LEN);
  localparam coord_t          N_S       = coord_t'(BOARD_N);
  localparam logic [CW-1:0]   LAST_STEP = CW'(WIN_LEN - 2);
  localparam logic [CW-1:0]   WIN_CNT   = CW'(WIN_LEN);
  localparam logic [CW-1:0]   ONE       = CW'(1);

  state_e        state;
  dir_e          dir;
  logic [NC-1:0] seen_map, seen_next, new_map;
  logic [6:0]    pos;
  logic          colour;
  coord_t        p_row, p_col, cur_r, cur_c;
  logic [CW-1:0] count, steps;

  logic          pick_any;
  logic [6:0]    pick_idx;
  logic          in_bounds, match;
  logic [6:0]    cur_idx;
  coord_t        dr, dc;
  dir_e          next_dir;

  assign new_map = board_state & ~seen_map;

  omok_new_stone_enc #(.N(NC)) u_enc (
    .req   (new_map),
    .any   (pick_any),
    .index (pick_idx)
  );

  assign dr       = dir_dr(dir);
  assign dc       = dir_dc(dir);
  assign next_dir = dir_e'(dir + 2'd1);

  // Bounds are checked on signed row/col so an edge cell never aliases the next row.
  always_comb begin
    in_bounds = (cur_r >= 5'sd0) && (cur_r < N_S) && (cur_c >= 5'sd0) && (cur_c < N_S);
    cur_idx   = '0;
    if (in_bounds) cur_idx = 7'(cur_r[3:0]) * 7'(BOARD_N) + 7'(cur_c[3:0]);
    match     = in_bounds && board_state[cur_idx] && (turn_map[cur_idx] == colour);
  end

  // Undone cells drop out of seen_map so a re-placed stone is scanned again.
  always_comb begin
    seen_next = seen_map & board_state;
    if (state == IDLE && pick_any) seen_next[pick_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;  dir <= DIR_E;  seen_map <= '0;
      pos <= '0;  colour <= BLACK;  p_row <= '0;  p_col <= '0;
      cur_r <= '0;  cur_c <= '0;  count <= '0;  steps <= '0;
      busy <= 1'b0;  done <= 1'b0;  win <= 1'b0;  winner <= 1'b0;  win_pos <= '0;
    end else if (~|board_state) begin
      state <= IDLE;  seen_map <= '0;
      busy <= 1'b0;  done <= 1'b0;  win <= 1'b0;  winner <= 1'b0;  win_pos <= '0;
    end else begin
      seen_map <= seen_next;
      done     <= 1'b0;
      case (state)
        IDLE: if (pick_any) begin
          pos    <= pick_idx;
          colour <= turn_map[pick_idx];
          p_row  <= coord_t'(pick_idx / 7'(BOARD_N));
          p_col  <= coord_t'(pick_idx % 7'(BOARD_N));
          if (win) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state <= DIR_INIT;
            busy  <= 1'b1;
          end
        end
        DIR_INIT: begin
          dir   <= DIR_E;
          count <= ONE;
          steps <= '0;
          cur_r <= p_row + dir_dr(DIR_E);
          cur_c <= p_col + dir_dc(DIR_E);
          state <= STEP_POS;
        end
        STEP_POS: begin
          if (match) count <= count + ONE;
          if (!match || steps == LAST_STEP) begin
            steps <= '0;
            cur_r <= p_row - dr;
            cur_c <= p_col - dc;
            state <= STEP_NEG;
          end else begin
            steps <= steps + ONE;
            cur_r <= cur_r + dr;
            cur_c <= cur_c + dc;
          end
        end
        STEP_NEG: begin
          if (match) count <= count + ONE;
          if (!match || steps == LAST_STEP) begin
            state <= EVAL;
          end else begin
            steps <= steps + ONE;
            cur_r <= cur_r - dr;
            cur_c <= cur_c - dc;
          end
        end
        EVAL: begin
          if (count >= WIN_CNT || dir == DIR_SW) begin
            if (count >= WIN_CNT) begin
              win     <= 1'b1;
              winner  <= colour;
              win_pos <= pos;
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            dir   <= next_dir;
            count <= ONE;
            steps <= '0;
            cur_r <= p_row + dir_dr(next_dir);
            cur_c <= p_col + dir_dc(next_dir);
            state <= STEP_POS;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_omok_win_detector.sv
// Directed bench for omok_win_detector: line wins, edges, ordering, reset and board clear.
module tb_omok_win_detector;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [99:0] board_state = '0;
  logic [99:0] turn_map = '0;
  logic        busy, done, win, winner;
  logic [6:0]  win_pos;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  omok_win_detector #(.BOARD_N(10), .WIN_LEN(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .board_state (board_state),
    .turn_map    (turn_map),
    .busy        (busy),
    .done        (done),
    .win         (win),
    .winner      (winner),
    .win_pos     (win_pos)
  );

  always #5 clk = ~clk;

  // Counts cycles with done high, so a stuck done shows up as extra pulses.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic place(input int idx, input logic col);
    @(posedge clk); #1;
    board_state[idx] = 1'b1;
    turn_map[idx]    = col;
    repeat (50) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic clear_board();
    @(posedge clk); #1;
    board_state = '0;
    turn_map    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({busy, done, win, winner, win_pos} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs got=%b want 0", {busy, done, win, winner, win_pos});
    end
    #6 rst = 1'b1;
  endtask

  task automatic test_row_black();
    int base;
    clear_board();
    base = done_cnt;
    for (int i = 0; i < 4; i++) begin
      place(42 + i, 1'b0);
      tests++;
      if (win !== 1'b0) begin
        fails++; $display("FAIL row_no_early_win stone=%0d win=%b want 0", 42 + i, win);
      end
      tests++;
      if (done_cnt !== base + i + 1) begin
        fails++; $display("FAIL row_done_count got=%0d want %0d", done_cnt - base, i + 1);
      end
    end
    place(46, 1'b0);
    tests++;
    if ({win, winner, win_pos} !== {1'b1, 1'b0, 7'd46}) begin
      fails++; $display("FAIL row_win got win=%b winner=%b pos=%0d want 1 0 46", win, winner, win_pos);
    end
    tests++;
    if (done_cnt !== base + 5) begin
      fails++; $display("FAIL row_done_total got=%0d want 5", done_cnt - base);
    end
    // A later stone after the win is absorbed with a done pulse but leaves the result alone.
    place(0, 1'b1);
    tests++;
    if ({win, winner, win_pos} !== {1'b1, 1'b0, 7'd46} || done_cnt !== base + 6) begin
      fails++;
      $display("FAIL win_sticky got win=%b winner=%b pos=%0d done=%0d want 1 0 46 6",
               win, winner, win_pos, done_cnt - base);
    end
  endtask

  task automatic test_diag_white();
    clear_board();
    @(posedge clk); #1;
    board_state[0] = 1'b1;
    turn_map[0]    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL diag_busy_after_pick got=%b want 1", busy);
    end
    repeat (50) @(posedge clk);
    place(11, 1'b1);
    place(22, 1'b1);
    place(33, 1'b1);
    place(44, 1'b1);
    tests++;
    if ({win, winner, win_pos} !== {1'b1, 1'b1, 7'd44}) begin
      fails++; $display("FAIL diag_win got win=%b winner=%b pos=%0d want 1 1 44", win, winner, win_pos);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL diag_busy_idle got=%b want 0", busy);
    end
  endtask

  task automatic test_no_wrap();
    int base;
    clear_board();
    base = done_cnt;
    for (int i = 7; i <= 11; i++) place(i, 1'b0);
    tests++;
    if (win !== 1'b0) begin
      fails++; $display("FAIL wrap_no_win got win=%b pos=%0d want 0", win, win_pos);
    end
    tests++;
    if (done_cnt !== base + 5) begin
      fails++; $display("FAIL wrap_done_count got=%0d want 5", done_cnt - base);
    end
  endtask

  task automatic test_blocked_and_neg();
    clear_board();
    place(51, 1'b0);
    place(52, 1'b0);
    place(53, 1'b0);
    place(54, 1'b1);
    place(50, 1'b0);
    // 50..53 black then white 54: only four in a row.
    tests++;
    if (win !== 1'b0) begin
      fails++; $display("FAIL blocked_no_win got win=%b pos=%0d want 0", win, win_pos);
    end
    for (int i = 71; i <= 74; i++) place(i, 1'b0);
    place(75, 1'b0);
    tests++;
    if ({win, winner, win_pos} !== {1'b1, 1'b0, 7'd75}) begin
      fails++; $display("FAIL neg_side_win got win=%b winner=%b pos=%0d want 1 0 75", win, winner, win_pos);
    end
  endtask

  task automatic test_same_cycle();
    int base;
    clear_board();
    place(0, 1'b0);
    place(10, 1'b0);
    place(40, 1'b0);
    base = done_cnt;
    @(posedge clk); #1;
    board_state[20] = 1'b1;
    board_state[30] = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if (done_cnt !== base + 2) begin
      fails++; $display("FAIL pair_done_count got=%0d want 2", done_cnt - base);
    end
    // 30 is already on the board when 20 is scanned, so the column completes at 20.
    tests++;
    if ({win, win_pos} !== {1'b1, 7'd20}) begin
      fails++; $display("FAIL pair_order got win=%b pos=%0d want 1 20", win, win_pos);
    end
  endtask

  task automatic test_reset_and_clear();
    clear_board();
    @(posedge clk); #1;
    board_state[55] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL midscan_busy got=%b want 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({busy, done, win, winner, win_pos} !== 11'd0) begin
      fails++; $display("FAIL async_reset got=%b want 0", {busy, done, win, winner, win_pos});
    end
    board_state = '0;
    #3 rst = 1'b1;
    for (int i = 60; i <= 64; i++) place(i, 1'b0);
    tests++;
    if ({win, win_pos} !== {1'b1, 7'd64}) begin
      fails++; $display("FAIL clear_setup_win got win=%b pos=%0d want 1 64", win, win_pos);
    end
    @(posedge clk); #1;
    board_state = '0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({win, winner, win_pos} !== 9'd0) begin
      fails++; $display("FAIL board_clear got win=%b winner=%b pos=%0d want 0 0 0", win, winner, win_pos);
    end
  endtask

  initial begin
    test_reset();
    test_row_black();
    test_diag_white();
    test_no_wrap();
    test_blocked_and_neg();
    test_same_cycle();
    test_reset_and_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
